latency_profiler: RTL and testbench
===================================

Name: latency_profiler

Overview:
Multi-channel successor to the single-flag recognition timer. Measures start-to-stop latency on N_CH independent channels at a parametrised tick resolution (ms, us, ...), and keeps per-channel last/min/max/run-count statistics with sticky overflow. It sits beside the gesture recognition pipeline, with one channel per stage (e.g. preprocess, CNN, total), and feeds debug/UART readout.

Parameters:
CLK_FREQ, 50_000_000, clk_50m frequency in Hz.
TICK_HZ, 1000, measurement resolution; DIV = CLK_FREQ/TICK_HZ clock cycles per tick; DIV >= 2 is required, else elaboration error.
N_CH, 4, number of independent channels.
CNT_W, 32, width of tick counts (last/min/max).
RUN_W, 16, width of the per-channel completed-run counter.

Ports:
clk_50m  in  1  system clock; single clock domain.
rst_n  in  1  asynchronous, active-low reset.
start  in  N_CH  per-channel start pulse (level sampled every cycle).
stop  in  N_CH  per-channel stop pulse.
clr  in  1  synchronous clear of all statistics and overflow flags.
busy  out  N_CH  channel is in RUN.
done  out  N_CH  one-cycle pulse when a measurement is recorded.
ovf  out  N_CH  sticky: the tick count saturated at least once.
last_ticks  out  N_CH*CNT_W  latest measurement; channel i occupies bits [i*CNT_W +: CNT_W].
min_ticks  out  N_CH*CNT_W  minimum since reset/clr.
max_ticks  out  N_CH*CNT_W  maximum since reset/clr.
run_cnt  out  N_CH*RUN_W  completed measurements since reset/clr.

Behaviour:
- Reset values: busy=0, done=0, ovf=0, last=0, min=all-ones, max=0, run_cnt=0. Internal state: IDLE, pre=0, cnt=0.
- Channels are fully independent. No shared prescaler.
- Per-channel FSM has two states, IDLE and RUN.
- IDLE + start: go to RUN; pre<=0, cnt<=0. A stop in the same cycle is ignored.
- IDLE + stop alone: ignored, no done.
- RUN without start/stop: pre increments. When pre==DIV-1, pre<=0 and cnt<=cnt+1.
- cnt saturates at 2^CNT_W-1. When an increment would wrap, cnt holds and ovf<=1.
- RUN + stop: measured value M = registered cnt, excluding the stop cycle's own increment. Record M and return to IDLE.
- Resulting latency: start sampled at cycle t0, stop at t1 gives M = floor((t1-t0-1)/DIV).
- RUN + start (no stop): restart. pre<=0, cnt<=0, stay in RUN, nothing recorded.
- RUN + start + stop in the same cycle: record M, then immediately restart (pre<=0, cnt<=0, stay in RUN).
- Recording a measurement:
  - last<=M.
  - min<=M if M<min.
  - max<=M if M>max.
  - run_cnt<=run_cnt+1, saturating at 2^RUN_W-1.
  - done=1 for exactly one cycle.
  - All of these are visible on the cycle after stop is sampled, i.e. latency 1.
- clr: min<=all-ones, max<=0, run_cnt<=0, ovf<=0. last, the FSM, pre and cnt are not affected; an in-flight run continues.
- clr + recording in the same cycle: the clear applies first, then the measurement. Result: min=max=last=M, run_cnt=1, done=1.
- clr + saturation in the same cycle: ovf ends at 1.
- rst_n asserted mid-run: immediate return to the reset values above, and the run is lost.
- All outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Package latency_profiler_pkg holds:
  - the state enum (IDLE, RUN);
  - a function calc_div(CLK_FREQ, TICK_HZ);
  - localparams for the min reset value (all-ones) and the saturation limits.
- Sub-module latency_chan holds the per-channel FSM, prescaler, saturating counter and statistics. It is instantiated N_CH times in a generate loop; the top only packs the flattened outputs.

Test Plan:
All tests use CLK_FREQ=50_000, TICK_HZ=1000 (DIV=50), N_CH=4, CNT_W=8, RUN_W=4.
1. Basic: ch0 start at t0, stop at t0+501 -> one cycle later last[0]=10, min=max=10, run_cnt=1, done[0] pulses 1 cycle, busy[0]=0. Repeat with stop at t0+500 -> last=9, min=9, max=10, run_cnt=2.
2. Independence and simultaneity: ch1 and ch2 start together; stop ch1 after 101 cycles and ch2 after 251 -> last[1]=2, last[2]=5. Channels 0 and 3 are unchanged; done pulses occur on different cycles.
3. Saturation: start ch3, wait 256*50+10 cycles, stop -> last[3]=255, ovf[3]=1 (sticky). Then clr -> ovf=0, min=255 (all-ones), max=0, run_cnt=0, last still 255.
4. Restart and back-to-back: ch0 start, start again after 120 cycles, stop 151 cycles later -> last=3, run_cnt+1 only. Then start+stop together while in RUN -> M recorded, busy stays 1, new run counts from 0.
5. Edge events: stop while IDLE -> no done, stats unchanged. start+stop while IDLE -> busy=1, no done. 16 completed runs -> run_cnt holds at 15. clr in the same cycle as a stop with M=7 -> min=max=last=7, run_cnt=1.
6. Async reset mid-run: assert rst_n low for 3 cycles during a ch0 run -> all outputs immediately return to their reset values; a subsequent stop without a new start records nothing.

Source files
------------

// File: rtl/latency_profiler_pkg.sv
// rtl/latency_profiler_pkg.sv - shared types, divider helper and saturation constants
// Contents:
//   chan_state_t   per-channel FSM state (IDLE, RUN)
//   calc_div()     clock cycles per measurement tick
//   SAT_MAX_W      widest supported count or run-counter width
//   MIN_RESET      reset/clear value for the minimum statistic
//   SAT_LIMIT      saturation limit for counters
`timescale 1ns/1ps
package latency_profiler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_t;

  // A minimum of all-ones means "no measurement yet", so the first
  // recorded value always wins the less-than compare.
  localparam int SAT_MAX_W = 64;
  localparam logic [SAT_MAX_W-1:0] MIN_RESET = '1;
  localparam logic [SAT_MAX_W-1:0] SAT_LIMIT = '1;

  // A zero or negative TICK_HZ yields 0, which the top rejects at elaboration.
  function automatic int calc_div(input int clk_freq, input int tick_hz);
    if (tick_hz <= 0) begin
      return 0;
    end
    return clk_freq / tick_hz;
  endfunction

endpackage

// File: rtl/latency_chan.sv
// rtl/latency_chan.sv - one latency channel: FSM, prescaler, saturating counter, statistics
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   start, stop      measurement control pulses, sampled every cycle
//   clr              synchronous clear of min/max/run_cnt/ovf
//   busy             channel is in RUN
//   done             one-cycle pulse when a measurement is recorded
//   ovf              sticky tick-count saturation flag
//   last_ticks       latest measurement
//   min_ticks        minimum since reset/clr
//   max_ticks        maximum since reset/clr
//   run_cnt          completed measurements, saturating
`timescale 1ns/1ps
module latency_chan
  import latency_profiler_pkg::*;
#(
  parameter int DIV   = 50,
  parameter int CNT_W = 32,
  parameter int RUN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clr,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [CNT_W-1:0] last_ticks,
  output logic [CNT_W-1:0] min_ticks,
  output logic [CNT_W-1:0] max_ticks,
  output logic [RUN_W-1:0] run_cnt
);

  localparam int PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = SAT_LIMIT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] MIN_INIT = MIN_RESET[CNT_W-1:0];
  localparam logic [RUN_W-1:0] RUN_MAX  = SAT_LIMIT[RUN_W-1:0];

  chan_state_t      state;
  logic [PRE_W-1:0] pre;
  logic [CNT_W-1:0] cnt;

  // Statistics as they stand after a same-cycle clr, so that a recording
  // in the clearing cycle behaves as if the clear happened first.
  logic [CNT_W-1:0] min_base;
  logic [CNT_W-1:0] max_base;
  logic [RUN_W-1:0] run_base;

  always_comb begin
    min_base = clr ? MIN_INIT : min_ticks;
    max_base = clr ? '0 : max_ticks;
    run_base = clr ? '0 : run_cnt;
  end

  // busy comes straight from the state flop, so it stays a registered output.
  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pre        <= '0;
      cnt        <= '0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      last_ticks <= '0;
      min_ticks  <= MIN_INIT;
      max_ticks  <= '0;
      run_cnt    <= '0;
    end else begin
      done <= 1'b0;

      if (clr) begin
        min_ticks <= MIN_INIT;
        max_ticks <= '0;
        run_cnt   <= '0;
        ovf       <= 1'b0;
      end

      case (state)
        IDLE: begin
          // A stop alongside the start is deliberately ignored.
          if (start) begin
            state <= RUN;
            pre   <= '0;
            cnt   <= '0;
          end
        end

        RUN: begin
          // The measured value is the registered count; the stop cycle
          // itself contributes no prescaler step.
          if (stop) begin
            done       <= 1'b1;
            last_ticks <= cnt;
            if (cnt < min_base) begin
              min_ticks <= cnt;
            end
            if (cnt > max_base) begin
              max_ticks <= cnt;
            end
            if (run_base != RUN_MAX) begin
              run_cnt <= run_base + RUN_W'(1);
            end
          end

          if (start) begin
            pre <= '0;
            cnt <= '0;
          end else if (stop) begin
            state <= IDLE;
          end else if (pre == PRE_LAST) begin
            pre <= '0;
            // Saturation is written after the clr block so that a clear
            // in the same cycle still leaves ovf set.
            if (cnt == CNT_MAX) begin
              ovf <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            pre <= pre + PRE_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/latency_profiler.sv
// rtl/latency_profiler.sv - multi-channel start-to-stop latency profiler with statistics
// Ports:
//   clk_50m      system clock
//   rst_n        asynchronous active-low reset
//   start[i]     channel i start pulse
//   stop[i]      channel i stop pulse
//   clr          synchronous clear of statistics and overflow flags
//   busy[i]      channel i is measuring
//   done[i]      channel i recorded a measurement this cycle
//   ovf[i]       channel i tick count saturated at least once (sticky)
//   last_ticks   latest measurement, channel i at [i*CNT_W +: CNT_W]
//   min_ticks    per-channel minimum, same packing
//   max_ticks    per-channel maximum, same packing
//   run_cnt      per-channel completed runs, channel i at [i*RUN_W +: RUN_W]
`timescale 1ns/1ps
module latency_profiler
  import latency_profiler_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int N_CH     = 4,
  parameter int CNT_W    = 32,
  parameter int RUN_W    = 16
) (
  input  logic                  clk_50m,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH-1:0]       stop,
  input  logic                  clr,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       done,
  output logic [N_CH-1:0]       ovf,
  output logic [N_CH*CNT_W-1:0] last_ticks,
  output logic [N_CH*CNT_W-1:0] min_ticks,
  output logic [N_CH*CNT_W-1:0] max_ticks,
  output logic [N_CH*RUN_W-1:0] run_cnt
);

  localparam int DIV = calc_div(CLK_FREQ, TICK_HZ);

  if (DIV < 2) begin : g_bad_div
    $error("latency_profiler: CLK_FREQ/TICK_HZ must be at least 2");
  end

  if (CNT_W > SAT_MAX_W || RUN_W > SAT_MAX_W) begin : g_bad_width
    $error("latency_profiler: CNT_W and RUN_W must not exceed 64");
  end

  // Each channel owns its prescaler so that start phases never interact.
  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    latency_chan #(
      .DIV   (DIV),
      .CNT_W (CNT_W),
      .RUN_W (RUN_W)
    ) u_chan (
      .clk        (clk_50m),
      .rst_n      (rst_n),
      .start      (start[i]),
      .stop       (stop[i]),
      .clr        (clr),
      .busy       (busy[i]),
      .done       (done[i]),
      .ovf        (ovf[i]),
      .last_ticks (last_ticks[i*CNT_W +: CNT_W]),
      .min_ticks  (min_ticks[i*CNT_W +: CNT_W]),
      .max_ticks  (max_ticks[i*CNT_W +: CNT_W]),
      .run_cnt    (run_cnt[i*RUN_W +: RUN_W])
    );
  end

endmodule

// File: tb/tb_latency_profiler.sv
// tb/tb_latency_profiler.sv - self-checking bench for latency_profiler
`timescale 1ns/1ps
module tb_latency_profiler;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;
  localparam int RUN_W = 4;

  logic                  clk_50m;
  logic                  rst_n;
  logic [N_CH-1:0]       start;
  logic [N_CH-1:0]       stop;
  logic                  clr;
  logic [N_CH-1:0]       busy;
  logic [N_CH-1:0]       done;
  logic [N_CH-1:0]       ovf;
  logic [N_CH*CNT_W-1:0] last_ticks;
  logic [N_CH*CNT_W-1:0] min_ticks;
  logic [N_CH*CNT_W-1:0] max_ticks;
  logic [N_CH*RUN_W-1:0] run_cnt;

  latency_profiler #(
    .CLK_FREQ (50_000),
    .TICK_HZ  (1000),
    .N_CH     (N_CH),
    .CNT_W    (CNT_W),
    .RUN_W    (RUN_W)
  ) dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .clr        (clr),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf),
    .last_ticks (last_ticks),
    .min_ticks  (min_ticks),
    .max_ticks  (max_ticks),
    .run_cnt    (run_cnt)
  );

  initial clk_50m = 1'b0;
  always #5 clk_50m = ~clk_50m;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    int ch;
    int m;
  } sb_t;
  sb_t sb[$];

  typedef struct packed {
    int ch;
    int d;
    int m;
    int mn;
    int mx;
    int rc;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] last_of(input int c);
    return 64'(last_ticks[c*CNT_W +: CNT_W]);
  endfunction
  function automatic logic [63:0] min_of(input int c);
    return 64'(min_ticks[c*CNT_W +: CNT_W]);
  endfunction
  function automatic logic [63:0] max_of(input int c);
    return 64'(max_ticks[c*CNT_W +: CNT_W]);
  endfunction
  function automatic logic [63:0] run_of(input int c);
    return 64'(run_cnt[c*RUN_W +: RUN_W]);
  endfunction

  // Every done pulse must match the oldest outstanding expected record.
  always @(negedge clk_50m) begin
    for (int c = 0; c < N_CH; c++) begin
      if (done[c] === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done ch%0d: got done=1 required 0", c);
        end else begin
          sb_t e;
          e = sb.pop_front();
          check("sb_channel", 64'(c), 64'(e.ch));
          check("sb_last", last_of(c), 64'(e.m));
        end
      end
    end
  end

  task automatic check_reset_all();
    for (int c = 0; c < N_CH; c++) begin
      check("rst_busy", 64'(busy[c]), 0);
      check("rst_done", 64'(done[c]), 0);
      check("rst_ovf", 64'(ovf[c]), 0);
      check("rst_last", last_of(c), 0);
      check("rst_min", min_of(c), 255);
      check("rst_max", max_of(c), 0);
      check("rst_run", run_of(c), 0);
    end
  endtask

  // Start sampled at edge t0, stop sampled at edge t0+d.
  task automatic measure(input int ch, input int d, input int m, input bit with_clr);
    start[ch] = 1'b1;
    @(posedge clk_50m); #1;
    start[ch] = 1'b0;
    repeat (d - 1) @(posedge clk_50m);
    #1;
    stop[ch] = 1'b1;
    clr      = with_clr;
    sb.push_back(sb_t'{ch: ch, m: m});
    @(posedge clk_50m); #1;
    stop[ch] = 1'b0;
    clr      = 1'b0;
    @(negedge clk_50m);
    check("done_pulse", 64'(done[ch]), 1);
    check("busy_after_stop", 64'(busy[ch]), 0);
    @(negedge clk_50m);
    check("done_width", 64'(done[ch]), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0;
    stop  = '0;
    clr   = 1'b0;

    vecs[0] = '{ch: 0, d: 501, m: 10, mn: 10, mx: 10, rc: 1};
    vecs[1] = '{ch: 0, d: 500, m: 9,  mn: 9,  mx: 10, rc: 2};
    vecs[2] = '{ch: 0, d: 1,   m: 0,  mn: 0,  mx: 10, rc: 3};
    vecs[3] = '{ch: 0, d: 51,  m: 1,  mn: 0,  mx: 10, rc: 4};
    vecs[4] = '{ch: 1, d: 151, m: 3,  mn: 3,  mx: 3,  rc: 1};

    repeat (3) @(posedge clk_50m);
    #1;
    check_reset_all();
    rst_n = 1'b1;
    @(posedge clk_50m); #1;

    // Basic measurements and running statistics
    for (int i = 0; i < 5; i++) begin
      measure(vecs[i].ch, vecs[i].d, vecs[i].m, 1'b0);
      check("vec_last", last_of(vecs[i].ch), 64'(vecs[i].m));
      check("vec_min", min_of(vecs[i].ch), 64'(vecs[i].mn));
      check("vec_max", max_of(vecs[i].ch), 64'(vecs[i].mx));
      check("vec_run", run_of(vecs[i].ch), 64'(vecs[i].rc));
    end

    // Simultaneous start on ch1/ch2, staggered stops
    start[1] = 1'b1;
    start[2] = 1'b1;
    @(posedge clk_50m); #1;
    start = '0;
    check("ind_busy1", 64'(busy[1]), 1);
    check("ind_busy2", 64'(busy[2]), 1);
    repeat (100) @(posedge clk_50m);
    #1;
    stop[1] = 1'b1;
    sb.push_back(sb_t'{ch: 1, m: 2});
    @(posedge clk_50m); #1;
    stop[1] = 1'b0;
    @(negedge clk_50m);
    check("ind_done1", 64'(done[1]), 1);
    check("ind_done2_quiet", 64'(done[2]), 0);
    check("ind_busy2_still", 64'(busy[2]), 1);
    repeat (149) @(posedge clk_50m);
    #1;
    stop[2] = 1'b1;
    sb.push_back(sb_t'{ch: 2, m: 5});
    @(posedge clk_50m); #1;
    stop[2] = 1'b0;
    @(negedge clk_50m);
    check("ind_done2", 64'(done[2]), 1);
    check("ind_last1", last_of(1), 2);
    check("ind_min1", min_of(1), 2);
    check("ind_max1", max_of(1), 3);
    check("ind_run1", run_of(1), 2);
    check("ind_last2", last_of(2), 5);
    check("ind_last0", last_of(0), 1);
    check("ind_run0", run_of(0), 4);
    check("ind_last3", last_of(3), 0);
    check("ind_run3", run_of(3), 0);

    // Saturation on ch3, then clr
    measure(3, 256 * 50 + 10, 255, 1'b0);
    check("sat_ovf", 64'(ovf[3]), 1);
    check("sat_min", min_of(3), 255);
    check("sat_max", max_of(3), 255);
    check("sat_run", run_of(3), 1);
    check("sat_ovf_others", 64'(ovf[2:0]), 0);
    repeat (5) @(posedge clk_50m);
    #1;
    check("sat_ovf_sticky", 64'(ovf[3]), 1);
    clr = 1'b1;
    @(posedge clk_50m); #1;
    clr = 1'b0;
    check("clr_ovf", 64'(ovf[3]), 0);
    check("clr_min3", min_of(3), 255);
    check("clr_max3", max_of(3), 0);
    check("clr_run3", run_of(3), 0);
    check("clr_last3", last_of(3), 255);
    check("clr_min0", min_of(0), 255);
    check("clr_run0", run_of(0), 0);
    check("clr_last0", last_of(0), 1);

    // Restart while running
    start[0] = 1'b1;
    @(posedge clk_50m); #1;
    start[0] = 1'b0;
    repeat (119) @(posedge clk_50m);
    #1;
    start[0] = 1'b1;
    @(posedge clk_50m); #1;
    start[0] = 1'b0;
    check("restart_busy", 64'(busy[0]), 1);
    check("restart_run", run_of(0), 0);
    repeat (150) @(posedge clk_50m);
    #1;
    stop[0] = 1'b1;
    sb.push_back(sb_t'{ch: 0, m: 3});
    @(posedge clk_50m); #1;
    stop[0] = 1'b0;
    @(negedge clk_50m);
    check("restart_last", last_of(0), 3);
    check("restart_run1", run_of(0), 1);

    // Start+stop together while running: record and restart
    start[0] = 1'b1;
    @(posedge clk_50m); #1;
    start[0] = 1'b0;
    @(negedge clk_50m);
    repeat (75) @(posedge clk_50m);
    #1;
    start[0] = 1'b1;
    stop[0]  = 1'b1;
    sb.push_back(sb_t'{ch: 0, m: 1});
    @(posedge clk_50m); #1;
    start[0] = 1'b0;
    stop[0]  = 1'b0;
    @(negedge clk_50m);
    check("b2b_done", 64'(done[0]), 1);
    check("b2b_busy", 64'(busy[0]), 1);
    check("b2b_last", last_of(0), 1);
    check("b2b_run", run_of(0), 2);
    repeat (100) @(posedge clk_50m);
    #1;
    stop[0] = 1'b1;
    sb.push_back(sb_t'{ch: 0, m: 2});
    @(posedge clk_50m); #1;
    stop[0] = 1'b0;
    @(negedge clk_50m);
    check("b2b_new_last", last_of(0), 2);
    check("b2b_new_run", run_of(0), 3);

    // Stop while idle is ignored
    stop[0] = 1'b1;
    @(posedge clk_50m); #1;
    stop[0] = 1'b0;
    @(negedge clk_50m);
    check("idle_stop_done", 64'(done[0]), 0);
    check("idle_stop_run", run_of(0), 3);
    check("idle_stop_last", last_of(0), 2);

    // Start+stop while idle just starts
    start[0] = 1'b1;
    stop[0]  = 1'b1;
    @(posedge clk_50m); #1;
    start[0] = 1'b0;
    stop[0]  = 1'b0;
    @(negedge clk_50m);
    check("idle_ss_busy", 64'(busy[0]), 1);
    check("idle_ss_done", 64'(done[0]), 0);
    repeat (59) @(posedge clk_50m);
    #1;
    stop[0] = 1'b1;
    sb.push_back(sb_t'{ch: 0, m: 1});
    @(posedge clk_50m); #1;
    stop[0] = 1'b0;
    @(negedge clk_50m);
    check("idle_ss_run", run_of(0), 4);

    // Run counter saturation
    for (int i = 0; i < 12; i++) begin
      measure(0, 1, 0, 1'b0);
    end
    check("run_sat", run_of(0), 15);
    check("run_sat_min", min_of(0), 0);

    // clr coincident with a recording
    measure(0, 351, 7, 1'b1);
    check("clr_rec_min", min_of(0), 7);
    check("clr_rec_max", max_of(0), 7);
    check("clr_rec_last", last_of(0), 7);
    check("clr_rec_run", run_of(0), 1);

    // Asynchronous reset mid-run
    start[0] = 1'b1;
    start[2] = 1'b1;
    @(posedge clk_50m); #1;
    start = '0;
    repeat (100) @(posedge clk_50m);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_all();
    repeat (3) @(posedge clk_50m);
    #1;
    rst_n = 1'b1;
    stop[0] = 1'b1;
    @(posedge clk_50m); #1;
    stop[0] = 1'b0;
    @(negedge clk_50m);
    check("post_rst_done", 64'(done[0]), 0);
    check("post_rst_busy", 64'(busy[0]), 0);
    check("post_rst_run", run_of(0), 0);
    check("post_rst_last", last_of(0), 0);
    repeat (3) @(posedge clk_50m);
    #1;

    check("sb_drained", 64'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
